// File: rtl/scope_capture.sv
// Multi-channel trigger/capture buffer: circular sample store, level/edge trigger
// with pre-trigger window, auto/normal/single/stop modes, strobe readout of one frame.

module scope_capture_bank #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge sys_clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

module scope_capture #(
  parameter int CH_NUM  = 2,
  parameter int DATA_W  = 12,
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 100000,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     sample_en,
  input  logic [CH_NUM*DATA_W-1:0] sample_data,
  input  logic [2:0]               trig_ch,
  input  logic [DATA_W-1:0]        trig_level,
  input  logic                     trig_edge,
  input  logic [AW-1:0]            pre_len,
  input  logic [1:0]               mode,
  input  logic                     arm,
  input  logic                     rd_en,
  output logic [CH_NUM*DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     frame_ready,
  output logic [2:0]               state
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;
  state_t cur, nxt;

  logic [CH_NUM-1:0][DATA_W-1:0] smp, rd_q;
  logic [DATA_W-1:0] sel, prev;
  logic [AW-1:0]     wptr, pre_q, pre_cnt, post_left, start, post_init;
  logic [AW:0]       rd_idx;
  logic [TW-1:0]     to_cnt;
  logic edge_hit, to_hit, stop, wr, rd_fire, last_rd, trig_fire, enter_pre, enter_done;

  assign smp       = sample_data;
  assign rd_data   = rd_q;
  assign state     = cur;
  assign stop      = (mode == 2'd3);
  assign post_init = {AW{1'b1}} - pre_q;

  always_comb begin
    sel = smp[0];
    for (int c = 0; c < CH_NUM; c++)
      if (3'(c) == trig_ch) sel = smp[c];
  end

  assign edge_hit  = sample_en && (trig_edge ? (prev < trig_level && sel >= trig_level)
                                             : (prev > trig_level && sel <= trig_level));
  assign to_hit    = sample_en && mode == 2'd0 && to_cnt == TW'(TIMEOUT - 1);
  assign wr        = sample_en && (cur == S_PRE || cur == S_WAIT || cur == S_POST);
  assign rd_fire   = cur == S_DONE && rd_en && !rd_idx[AW];
  assign last_rd   = cur == S_DONE && rd_valid && rd_idx[AW];
  assign trig_fire = cur == S_WAIT && !stop && (edge_hit || to_hit);

  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE: if (mode == 2'd0 || mode == 2'd1 || (mode == 2'd2 && arm)) nxt = S_PRE;
      S_PRE:
        if (stop)                                               nxt = S_IDLE;
        else if (pre_q == '0)                                   nxt = S_WAIT;
        else if (sample_en && pre_cnt == pre_q - 1'b1)          nxt = S_WAIT;
      // A zero-length post window skips POST so no extra write can clobber the oldest sample.
      S_WAIT:
        if (stop)           nxt = S_IDLE;
        else if (trig_fire) nxt = (post_init == '0) ? S_DONE : S_POST;
      S_POST:
        if (stop)                                    nxt = S_IDLE;
        else if (sample_en && post_left == AW'(1))   nxt = S_DONE;
      S_DONE:
        if (last_rd) nxt = (mode == 2'd0 || mode == 2'd1) ? S_PRE : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  assign enter_pre  = nxt == S_PRE  && cur != S_PRE;
  assign enter_done = nxt == S_DONE && cur != S_DONE;

  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      prev <= '0; wptr <= '0; pre_q <= '0; pre_cnt <= '0; post_left <= '0;
      start <= '0; rd_idx <= '0; to_cnt <= '0; frame_ready <= 1'b0; rd_valid <= 1'b0;
    end else begin
      if (sample_en) prev <= sel;
      if (wr)        wptr <= wptr + 1'b1;
      if (enter_pre) begin
        pre_q   <= pre_len;
        pre_cnt <= '0;
      end else if (cur == S_PRE && sample_en) pre_cnt <= pre_cnt + 1'b1;
      if (cur != S_WAIT)  to_cnt <= '0;
      else if (sample_en) to_cnt <= to_cnt + 1'b1;
      // Trigger sample lands at wptr; frame starts pre_q entries before it.
      if (trig_fire) begin
        start     <= wptr - pre_q;
        post_left <= post_init;
      end else if (cur == S_POST && sample_en) post_left <= post_left - 1'b1;
      if (enter_done) begin
        frame_ready <= 1'b1;
        rd_idx      <= '0;
      end else if (rd_fire) rd_idx <= rd_idx + 1'b1;
      if (last_rd) frame_ready <= 1'b0;
      rd_valid <= rd_fire;
    end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_bank
    scope_capture_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_bank (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .we      (wr),
      .waddr   (wptr),
      .wdata   (smp[c]),
      .re      (rd_fire),
      .raddr   (start + rd_idx[AW-1:0]),
      .rdata   (rd_q[c])
    );
  end
endmodule

// File: tb/tb_scope_capture.sv
// Directed bench for scope_capture: expected frame samples queued by stimulus,
// popped and compared by a monitor on each rd_valid.

module tb_scope_capture;
  localparam int CH = 2, DW = 12, DEPTH = 16, AW = 4;

  logic          sys_clk = 1'b0, rst_n = 1'b0;
  logic          sample_en = 1'b0, trig_edge = 1'b1, arm = 1'b0, rd_en = 1'b0;
  logic [CH*DW-1:0] sample_data = '0, rd_data;
  logic [2:0]    trig_ch = 3'd0, state;
  logic [DW-1:0] trig_level = 12'h800;
  logic [AW-1:0] pre_len = 4'd4;
  logic [1:0]    mode = 2'd1;
  logic          rd_valid, frame_ready;

  int total = 0, bad = 0, rv_cnt = 0;
  logic [CH*DW-1:0] exp_q[$];

  scope_capture #(.CH_NUM(CH), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(32)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .sample_en(sample_en), .sample_data(sample_data),
    .trig_ch(trig_ch), .trig_level(trig_level), .trig_edge(trig_edge), .pre_len(pre_len),
    .mode(mode), .arm(arm), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .frame_ready(frame_ready), .state(state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Scoreboard monitor: every rd_valid must match the oldest queued expectation.
  always @(negedge sys_clk) begin
    if (rst_n && rd_valid) begin
      rv_cnt++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rd_valid got=%h exp=none", rd_data);
      end else chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic samp(input logic [CH*DW-1:0] d);
    sample_en = 1'b1; sample_data = d;
    tick(1);
    sample_en = 1'b0;
  endtask

  task automatic ramp(input int n);
    for (int i = 0; i < n; i++) samp({12'h000, 12'(i * 'h80)});
  endtask

  task automatic rd(input logic [CH*DW-1:0] e);
    exp_q.push_back(e);
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [2:0] ch, input logic edg,
                          input logic [DW-1:0] lvl, input logic [AW-1:0] pl);
    rst_n = 1'b0; tick(1);
    mode = m; trig_ch = ch; trig_edge = edg; trig_level = lvl; pre_len = pl;
    rst_n = 1'b1; tick(2);
  endtask

  initial begin
    // Reset values
    tick(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_fr", 32'(frame_ready), 32'd0);
    chk("rst_rv", 32'(rd_valid), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);

    // 1: normal rising trigger, pre_len 4
    do_reset(2'd1, 3'd0, 1'b1, 12'h800, 4'd4);
    chk("t1_pre", 32'(state), 32'd1);
    ramp(27);
    chk("t1_fr_early", 32'(frame_ready), 32'd0);
    samp({12'h000, 12'hD80});
    chk("t1_fr", 32'(frame_ready), 32'd1);
    chk("t1_done", 32'(state), 32'd4);
    for (int i = 0; i < 16; i++) rd({12'h000, 12'(12'h600 + i * 'h80)});
    tick(1);
    chk("t1_fr_clr", 32'(frame_ready), 32'd0);
    chk("t1_state_pre", 32'(state), 32'd1);
    rd_en = 1'b1; tick(2); rd_en = 1'b0;   // ignored outside DONE
    chk("t1_rv_cnt", 32'(rv_cnt), 32'd16);

    // 2: ch1 falling, pre_len 0
    do_reset(2'd1, 3'd1, 1'b0, 12'h400, 4'd0);
    rv_cnt = 0;
    for (int k = 0; k < 28; k++) samp({12'(12'hFFF - k * 'h100), 12'h123});
    chk("t2_fr", 32'(frame_ready), 32'd1);
    for (int i = 0; i < 16; i++) rd({12'(12'h3FF - i * 'h100), 12'h123});
    tick(1);
    chk("t2_rv_cnt", 32'(rv_cnt), 32'd16);

    // 3: auto mode timeout, constant input
    do_reset(2'd0, 3'd0, 1'b1, 12'h800, 4'd4);
    for (int k = 0; k < 46; k++) samp({12'h555, 12'h555});
    chk("t3_fr_46", 32'(frame_ready), 32'd0);
    samp({12'h555, 12'h555});
    chk("t3_fr_47", 32'(frame_ready), 32'd1);
    for (int i = 0; i < 16; i++) rd({12'h555, 12'h555});
    tick(1);

    // 4: single mode needs arm
    do_reset(2'd2, 3'd0, 1'b1, 12'h800, 4'd4);
    ramp(28);
    chk("t4_noarm_state", 32'(state), 32'd0);
    chk("t4_noarm_fr", 32'(frame_ready), 32'd0);
    arm = 1'b1; tick(1); arm = 1'b0;
    chk("t4_arm_pre", 32'(state), 32'd1);
    ramp(28);
    chk("t4_fr", 32'(frame_ready), 32'd1);
    for (int i = 0; i < 16; i++) rd({12'h000, 12'(12'h600 + i * 'h80)});
    tick(1);
    chk("t4_idle", 32'(state), 32'd0);
    ramp(28);
    chk("t4_stay_idle", 32'(state), 32'd0);

    // 5: stop during POST
    do_reset(2'd1, 3'd0, 1'b1, 12'h800, 4'd4);
    ramp(19);
    chk("t5_post", 32'(state), 32'd3);
    mode = 2'd3; tick(1);
    chk("t5_idle", 32'(state), 32'd0);
    chk("t5_fr", 32'(frame_ready), 32'd0);
    rv_cnt = 0;
    rd_en = 1'b1; tick(2); rd_en = 1'b0;
    chk("t5_no_rv", 32'(rv_cnt), 32'd0);
    mode = 2'd1; tick(1);
    chk("t5_pre", 32'(state), 32'd1);

    // 6: async reset mid-readout
    do_reset(2'd1, 3'd0, 1'b1, 12'h800, 4'd4);
    ramp(28);
    for (int i = 0; i < 5; i++) rd({12'h000, 12'(12'h600 + i * 'h80)});
    #5;
    rst_n = 1'b0; #1;
    chk("t6_state", 32'(state), 32'd0);
    chk("t6_fr", 32'(frame_ready), 32'd0);
    chk("t6_rv", 32'(rd_valid), 32'd0);
    chk("t6_rd", 32'(rd_data), 32'd0);
    @(posedge sys_clk); #1;
    rst_n = 1'b1; tick(1);
    chk("t6_pre", 32'(state), 32'd1);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
